// File: rtl/shared_reg_arbiter.sv
// Round-robin write-port controller for one shared WIDTH-bit register.
// One requester owns the register per tenure; a tenure ends after MAX_HOLD writes or when its request drops.
module shared_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  localparam int OW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [OW-1:0]         owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [OW-1:0]   ptr;
  logic [HW-1:0]   hold_cnt;
  logic [OW-1:0]   winner;
  logic            found;
  logic [OW-1:0]   next_ptr;
  logic            last_write;
  logic [WIDTH-1:0] owner_data;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  assign next_ptr   = (owner == OW'(NREQ-1)) ? '0 : owner + 1'b1;
  assign last_write = (hold_cnt == HW'(MAX_HOLD-1));
  assign owner_data = req_data[int'(owner)*WIDTH +: WIDTH];
  assign busy       = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          q_valid <= 1'b0;
          if (found) begin
            grant         <= '0;
            grant[winner] <= 1'b1;
            owner         <= winner;
            hold_cnt      <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (req[owner]) begin
            q       <= owner_data;
            q_valid <= 1'b1;
          end else begin
            q_valid <= 1'b0;
          end
          // Release on the final permitted write or as soon as the owner lets go.
          if (!req[owner] || last_write) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= next_ptr;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter at NREQ=4, WIDTH=8, MAX_HOLD=4.
module tb_shared_reg_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;
  logic        q_valid;

  int total = 0;
  int bad   = 0;

  shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .owner(owner), .busy(busy), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req = '0; req_data = '0; rst = 1'b1;
    edge1();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    edge1(); edge1();
    total++;
    if ({grant, owner, busy, q, q_valid} !== 16'h0) begin
      bad++; $display("FAIL reset_state got g=%b o=%0d b=%b q=%h v=%b want all zero", grant, owner, busy, q, q_valid);
    end
    rst = 1'b0;
    req = 4'b0001; req_data[7:0] = 8'h3C;
    edge1(); edge1();
    total++;
    if (q !== 8'h3C || grant !== 4'b0001) begin
      bad++; $display("FAIL reset_preload got q=%h g=%b want q=3c g=0001", q, grant);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (grant !== 4'b0 || q !== 8'h00 || q_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_async got g=%b q=%h v=%b b=%b want 0", grant, q, q_valid, busy);
    end
    #1 rst = 1'b0;
    req = 4'b1010;
    edge1();
    total++;
    if (grant !== 4'b0010 || owner !== 2'd1) begin
      bad++; $display("FAIL reset_ptr0 got g=%b o=%0d want g=0010 o=1", grant, owner);
    end
  endtask

  task automatic test_single();
    logic [11:0] gexp;
    logic [11:0] vexp;
    gexp = 12'b110111101111;  // bit e-1 = grant expected after edge e
    vexp = 12'b101111011110;
    do_reset();
    req = 4'b0100; req_data[23:16] = 8'hA5;
    for (int e = 1; e <= 12; e++) begin
      edge1();
      total++;
      if (grant !== (gexp[e-1] ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL single_grant e=%0d got %b want %b", e, grant, gexp[e-1] ? 4'b0100 : 4'b0000);
      end
      total++;
      if (q_valid !== vexp[e-1]) begin
        bad++; $display("FAIL single_qvalid e=%0d got %b want %b", e, q_valid, vexp[e-1]);
      end
      total++;
      if (q !== (e >= 2 ? 8'hA5 : 8'h00)) begin
        bad++; $display("FAIL single_q e=%0d got %h want %h", e, q, e >= 2 ? 8'hA5 : 8'h00);
      end
      if (e == 5) begin
        total++;
        if (owner !== 2'd2 || busy !== 1'b0) begin
          bad++; $display("FAIL single_idle_owner got o=%0d b=%b want o=2 b=0", owner, busy);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gw;
    logic [7:0] dw;
    do_reset();
    req = 4'b1111; req_data = 32'h13121110;
    for (int t = 0; t < 5; t++) begin
      gw = 4'b0001 << (t % 4);
      dw = 8'h10 + 8'(t % 4);
      edge1();
      total++;
      if (grant !== gw || q_valid !== 1'b0) begin
        bad++; $display("FAIL rr_grant t=%0d got g=%b v=%b want g=%b v=0", t, grant, q_valid, gw);
      end
      if (t < 4) begin
        for (int w = 0; w < 4; w++) begin
          edge1();
          total++;
          if (q !== dw || q_valid !== 1'b1) begin
            bad++; $display("FAIL rr_write t=%0d w=%0d got q=%h v=%b want q=%h v=1", t, w, q, q_valid, dw);
          end
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0001; req_data[7:0] = 8'h21; req_data[31:24] = 8'h33;
    edge1();
    edge1();
    req_data[7:0] = 8'h22;
    edge1();
    total++;
    if (q !== 8'h22 || grant !== 4'b0001) begin
      bad++; $display("FAIL early_second_write got q=%h g=%b want q=22 g=0001", q, grant);
    end
    req = 4'b0000;
    edge1();
    total++;
    if (grant !== 4'b0 || q !== 8'h22 || q_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL early_drop got g=%b q=%h v=%b b=%b want g=0 q=22 v=0 b=0", grant, q, q_valid, busy);
    end
    req = 4'b1001;
    edge1();
    total++;
    if (grant !== 4'b1000 || owner !== 2'd3) begin
      bad++; $display("FAIL early_req3_first got g=%b o=%0d want g=1000 o=3", grant, owner);
    end
    for (int w = 0; w < 4; w++) edge1();
    total++;
    if (q !== 8'h33 || grant !== 4'b0) begin
      bad++; $display("FAIL early_req3_tenure got q=%h g=%b want q=33 g=0", q, grant);
    end
    edge1();
    total++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      bad++; $display("FAIL early_req0_next got g=%b o=%0d want g=0001 o=0", grant, owner);
    end
  endtask

  task automatic test_data_tracking();
    logic [7:0] junk;
    do_reset();
    req = 4'b0010;
    edge1();
    for (int k = 1; k <= 3; k++) begin
      junk = (k % 2) ? 8'hAA : 8'h55;
      req = (k % 2) ? 4'b1011 : 4'b0110;
      req_data = {junk, ~junk, 8'(k), junk};
      edge1();
      total++;
      if (q !== 8'(k) || q_valid !== 1'b1 || grant !== 4'b0010) begin
        bad++; $display("FAIL track k=%0d got q=%h v=%b g=%b want q=%h v=1 g=0010", k, q, q_valid, grant, 8'(k));
      end
    end
  endtask

  task automatic test_wrap_starvation();
    int wait0, wait3, max0, max3;
    logic [3:0] gw;
    wait0 = 0; wait3 = 0; max0 = 0; max3 = 0;
    do_reset();
    req = 4'b1001; req_data = 32'hC0_00_00_0C;
    for (int e = 1; e <= 30; e++) begin
      edge1();
      wait0 = grant[0] ? 0 : wait0 + 1;
      wait3 = grant[3] ? 0 : wait3 + 1;
      if (wait0 > max0) max0 = wait0;
      if (wait3 > max3) max3 = wait3;
      if ((e - 1) % 5 == 0) begin
        gw = (((e - 1) / 5) % 2 == 1) ? 4'b1000 : 4'b0001;
        total++;
        if (grant !== gw) begin
          bad++; $display("FAIL wrap_grant e=%0d got %b want %b", e, grant, gw);
        end
      end
    end
    total++;
    if (max0 > 6 || max3 > 6) begin
      bad++; $display("FAIL starve_bound got max0=%0d max3=%0d want <=6", max0, max3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_data_tracking();
    test_wrap_starvation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
